// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU op bit
// positions, mem_inst_bus bit positions and the divider state encoding.
package exe_pkg;

    localparam int DS_BUS_W     = 155;
    localparam int ES_BUS_W     = 78;
    localparam int RF_COLLECT_W = 39;
    localparam int DIV_ITERS    = 32;

    localparam int ALU_OP_W    = 19;
    localparam int ALU_ADD     = 0;
    localparam int ALU_SUB     = 1;
    localparam int ALU_SLT     = 2;
    localparam int ALU_SLTU    = 3;
    localparam int ALU_AND     = 4;
    localparam int ALU_NOR     = 5;
    localparam int ALU_OR      = 6;
    localparam int ALU_XOR     = 7;
    localparam int ALU_SLL     = 8;
    localparam int ALU_SRL     = 9;
    localparam int ALU_SRA     = 10;
    localparam int ALU_LUI     = 11;
    localparam int ALU_MOD_WU  = 12;
    localparam int ALU_DIV_WU  = 13;
    localparam int ALU_MOD_W   = 14;
    localparam int ALU_DIV_W   = 15;
    localparam int ALU_MULH_WU = 16;
    localparam int ALU_MULH_W  = 17;
    localparam int ALU_MUL_W   = 18;

    localparam int MEM_LD_W  = 7;
    localparam int MEM_LD_H  = 6;
    localparam int MEM_LD_HU = 5;
    localparam int MEM_LD_B  = 4;
    localparam int MEM_LD_BU = 3;
    localparam int MEM_ST_W  = 2;
    localparam int MEM_ST_H  = 1;
    localparam int MEM_ST_B  = 0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/exe_stage_div_iter.sv
// Restoring radix-2 unsigned divider. Operands are captured on start,
// one quotient bit is produced per BUSY cycle, and the result is held
// in DONE until the consumer acknowledges it. early_i lets the caller
// skip the iterations when the answer is already known.
module div_iter
    import exe_pkg::*;
#(
    parameter int ITERS = DIV_ITERS
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        early_i,
    input  logic        ack_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    localparam int CNT_W = $clog2(ITERS);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        quot_q;
    logic [31:0]        rem_q;
    logic [31:0]        div_q;

    logic [31:0]        shifted;
    logic [31:0]        diff;
    logic               ge;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= DIV_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: IDLE -> BUSY (or DONE on early-out) -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start_i) state_d = early_i ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (cnt_q == '0) state_d = DIV_DONE;
            DIV_DONE: if (ack_i) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy_o = (state_q == DIV_BUSY);
        done_o = (state_q == DIV_DONE);
    end

    // One restoring step; rem_q[31] set means the 33-bit partial remainder
    // already exceeds any 32-bit divisor, and the wrapped 32-bit difference
    // is then still the correct new remainder
    always_comb begin
        shifted = {rem_q[30:0], quot_q[31]};
        diff    = shifted - div_q;
        ge      = rem_q[31] | (shifted >= div_q);
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        div_q <= b_i;
                        cnt_q <= CNT_W'(ITERS - 1);
                        if (early_i) begin
                            quot_q <= (b_i == '0) ? '1 : '0;
                            rem_q  <= a_i;
                        end else begin
                            quot_q <= a_i;
                            rem_q  <= '0;
                        end
                    end
                end
                DIV_BUSY: begin
                    quot_q <= {quot_q[30:0], ge};
                    rem_q  <= ge ? diff : shifted;
                    cnt_q  <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the LoongArch-32 pipeline: ALU, single-cycle multiply,
// iterative divide, data-SRAM request and forwarding bundle to decode.
// Optional build macro EXE_DIV_EARLY_OUT_EN: divider finishes in one cycle
// when the divisor is zero or |dividend| < |divisor|.
module exe_stage
    import exe_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ds_to_es_valid,
    output logic                    es_allowin,
    input  logic [DS_BUS_W-1:0]     ds_to_es_bus,
    input  logic [7:0]              mem_inst_bus,
    input  logic                    ms_allowin,
    output logic                    es_to_ms_valid,
    output logic [ES_BUS_W-1:0]     es_to_ms_bus,
    output logic [RF_COLLECT_W-1:0] es_rf_collect,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_we,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    logic                es_valid_q, es_valid_d;
    logic [DS_BUS_W-1:0] ds_bus_q, ds_bus_d;
    logic [7:0]          mem_inst_q, mem_inst_d;

    logic [ALU_OP_W-1:0] alu_op;
    logic                res_from_mem;
    logic [31:0]         src1, src2;
    logic                mem_en;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [31:0]         rkd_value;
    logic [31:0]         pc;

    logic [31:0] alu_result;
    logic [31:0] es_result;
    logic        es_ready_go;
    logic        es_block;

    logic        mul_signed;
    logic [63:0] mul_a, mul_b, mul_prod;

    logic        div_op, div_signed, div_is_mod, div_by_zero;
    logic [31:0] mag_a, mag_b;
    logic        div_start, div_early, div_ack;
    logic        div_busy, div_done;
    logic [31:0] div_quot, div_rem;
    logic [31:0] quot_fix, rem_fix, div_result;

    logic [3:0]  store_we;

    assign {alu_op, res_from_mem, src1, src2, mem_en, rf_we,
            rf_waddr, rkd_value, pc} = ds_bus_q;

    assign div_op      = |alu_op[ALU_DIV_W:ALU_MOD_WU];
    assign es_ready_go = ~div_op | div_done;
    assign es_allowin  = ~es_valid_q | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid_q & es_ready_go;

    // Pipeline register next state: valid follows decode whenever we can
    // accept, payload only loads on an actual transfer
    always_comb begin
        es_valid_d = es_valid_q;
        ds_bus_d   = ds_bus_q;
        mem_inst_d = mem_inst_q;
        if (es_allowin) es_valid_d = ds_to_es_valid;
        if (ds_to_es_valid & es_allowin) begin
            ds_bus_d   = ds_to_es_bus;
            mem_inst_d = mem_inst_bus;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            es_valid_q <= 1'b0;
            ds_bus_q   <= '0;
            mem_inst_q <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            ds_bus_q   <= ds_bus_d;
            mem_inst_q <= mem_inst_d;
        end
    end

    // Single-cycle ALU; op vector is one-hot, all-zero yields zero
    always_comb begin
        alu_result = '0;
        if      (alu_op[ALU_ADD])  alu_result = src1 + src2;
        else if (alu_op[ALU_SUB])  alu_result = src1 - src2;
        else if (alu_op[ALU_SLT])  alu_result = {31'b0, $signed(src1) < $signed(src2)};
        else if (alu_op[ALU_SLTU]) alu_result = {31'b0, src1 < src2};
        else if (alu_op[ALU_AND])  alu_result = src1 & src2;
        else if (alu_op[ALU_NOR])  alu_result = ~(src1 | src2);
        else if (alu_op[ALU_OR])   alu_result = src1 | src2;
        else if (alu_op[ALU_XOR])  alu_result = src1 ^ src2;
        else if (alu_op[ALU_SLL])  alu_result = src1 << src2[4:0];
        else if (alu_op[ALU_SRL])  alu_result = src1 >> src2[4:0];
        else if (alu_op[ALU_SRA])  alu_result = $signed(src1) >>> src2[4:0];
        else if (alu_op[ALU_LUI])  alu_result = src2;
    end

    // 33x33 signed multiply; the low 64 bits of a 64-bit product of the
    // extended operands are identical, so only 64 bits are formed
    always_comb begin
        mul_signed = alu_op[ALU_MULH_W] | alu_op[ALU_MUL_W];
        mul_a      = {{32{mul_signed & src1[31]}}, src1};
        mul_b      = {{32{mul_signed & src2[31]}}, src2};
        mul_prod   = mul_a * mul_b;
    end

    // Divide operand preparation: magnitudes go to the unsigned core
    always_comb begin
        div_signed  = alu_op[ALU_DIV_W] | alu_op[ALU_MOD_W];
        div_is_mod  = alu_op[ALU_MOD_W] | alu_op[ALU_MOD_WU];
        div_by_zero = (src2 == '0);
        mag_a       = (div_signed & src1[31]) ? -src1 : src1;
        mag_b       = (div_signed & src2[31]) ? -src2 : src2;
    end

`ifdef EXE_DIV_EARLY_OUT_EN
    assign div_early = div_by_zero | (mag_a < mag_b);
`else
    assign div_early = 1'b0;
`endif

    assign div_start = es_valid_q & div_op & ~div_busy & ~div_done;
    assign div_ack   = es_to_ms_valid & ms_allowin;

    div_iter #(
        .ITERS (DIV_ITERS)
    ) u_div_iter (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (div_start),
        .early_i     (div_early),
        .ack_i       (div_ack),
        .a_i         (mag_a),
        .b_i         (mag_b),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quot),
        .remainder_o (div_rem)
    );

    // Sign fix-up: quotient sign is the xor of operand signs, remainder
    // follows the dividend; divide-by-zero has a fixed architectural result
    always_comb begin
        quot_fix   = (div_signed & (src1[31] ^ src2[31])) ? -div_quot : div_quot;
        rem_fix    = (div_signed & src1[31]) ? -div_rem : div_rem;
        if (div_by_zero) begin
            quot_fix = '1;
            rem_fix  = src1;
        end
        div_result = div_is_mod ? rem_fix : quot_fix;
    end

    // Final result selection across ALU, multiplier and divider
    always_comb begin
        es_result = alu_result;
        if (div_op)                                        es_result = div_result;
        else if (alu_op[ALU_MUL_W])                        es_result = mul_prod[31:0];
        else if (alu_op[ALU_MULH_W] | alu_op[ALU_MULH_WU]) es_result = mul_prod[63:32];
    end

    // Store byte-lane enables and replicated write data
    always_comb begin
        store_we        = 4'b0000;
        data_sram_wdata = rkd_value;
        if (mem_inst_q[MEM_ST_W]) begin
            store_we = 4'b1111;
        end else if (mem_inst_q[MEM_ST_H]) begin
            store_we        = alu_result[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{rkd_value[15:0]}};
        end else if (mem_inst_q[MEM_ST_B]) begin
            store_we        = 4'b0001 << alu_result[1:0];
            data_sram_wdata = {4{rkd_value[7:0]}};
        end
    end

    assign data_sram_en   = es_valid_q & (res_from_mem | mem_en) & ms_allowin;
    assign data_sram_we   = data_sram_en ? store_we : 4'b0000;
    assign data_sram_addr = alu_result;

    assign es_block = es_valid_q & (res_from_mem | (div_op & ~div_done));

    assign es_to_ms_bus  = {mem_inst_q[MEM_LD_W:MEM_LD_BU], alu_result[1:0],
                            res_from_mem, rf_we, rf_waddr, es_result, pc};
    assign es_rf_collect = {es_block, es_valid_q & rf_we, rf_waddr, es_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage with hand-computed expected values.
module tb_exe_stage;
    import exe_pkg::*;

`ifdef EXE_DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    logic                    clk = 1'b0;
    logic                    resetn;
    logic                    ds_to_es_valid;
    logic                    es_allowin;
    logic [DS_BUS_W-1:0]     ds_to_es_bus;
    logic [7:0]              mem_inst_bus;
    logic                    ms_allowin;
    logic                    es_to_ms_valid;
    logic [ES_BUS_W-1:0]     es_to_ms_bus;
    logic [RF_COLLECT_W-1:0] es_rf_collect;
    logic                    data_sram_en;
    logic [3:0]              data_sram_we;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;

    int checkCount = 0;
    int passCount  = 0;

    exe_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_to_es_valid  (ds_to_es_valid),
        .es_allowin      (es_allowin),
        .ds_to_es_bus    (ds_to_es_bus),
        .mem_inst_bus    (mem_inst_bus),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_rf_collect   (es_rf_collect),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    function automatic logic [DS_BUS_W-1:0] makeBus(input int opIdx, input logic resFromMem,
            input logic [31:0] s1, input logic [31:0] s2, input logic memEn, input logic rfWe,
            input logic [4:0] waddr, input logic [31:0] rkd, input logic [31:0] pcVal);
        logic [18:0] op;
        op = '0;
        if (opIdx >= 0) op[opIdx] = 1'b1;
        return {op, resFromMem, s1, s2, memEn, rfWe, waddr, rkd, pcVal};
    endfunction

    // Present one bundle for a single edge; returns at the negedge of the
    // first cycle the bundle sits in the stage
    task automatic applyStimulus(input logic [DS_BUS_W-1:0] bus, input logic [7:0] memInst);
        ds_to_es_bus   = bus;
        mem_inst_bus   = memInst;
        ds_to_es_valid = 1'b1;
        @(negedge clk);
        ds_to_es_valid = 1'b0;
    endtask

    task automatic runAlu(input string tag, input int opIdx, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        applyStimulus(makeBus(opIdx, 1'b0, a, b, 1'b0, 1'b1, 5'd4, 32'h0, 32'h1c00_0100), 8'h00);
        checkOutput({tag, " valid"}, 32'(es_to_ms_valid), 32'd1);
        checkOutput(tag, es_to_ms_bus[63:32], exp);
        @(negedge clk);
    endtask

    task automatic runDiv(input string tag, input int opIdx, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int expLat);
        int lat;
        applyStimulus(makeBus(opIdx, 1'b0, a, b, 1'b0, 1'b1, 5'd9, 32'h0, 32'h1c00_0200), 8'h00);
        checkOutput({tag, " block"}, 32'(es_rf_collect[38]), 32'd1);
        lat = 0;
        while (!es_to_ms_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput(tag, es_to_ms_bus[63:32], exp);
        checkOutput({tag, " unblock"}, 32'(es_rf_collect[38]), 32'd0);
        @(negedge clk);
        checkOutput({tag, " drained"}, 32'(es_to_ms_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn         = 1'b0;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        mem_inst_bus   = '0;
        ms_allowin     = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("reset valid", 32'(es_to_ms_valid), 32'd0);
        checkOutput("reset allowin", 32'(es_allowin), 32'd1);
        checkOutput("reset sram_en", 32'(data_sram_en), 32'd0);
        checkOutput("reset sram_we", 32'(data_sram_we), 32'd0);
        checkOutput("reset rf_we", 32'(es_rf_collect[37]), 32'd0);
        checkOutput("reset pc", es_to_ms_bus[31:0], 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Basic add with forwarding fields
        applyStimulus(makeBus(ALU_ADD, 1'b0, 32'd5, 32'd7, 1'b0, 1'b1, 5'd3, 32'h0, 32'h1c00_0000), 8'h00);
        checkOutput("add valid", 32'(es_to_ms_valid), 32'd1);
        checkOutput("add result", es_to_ms_bus[63:32], 32'd12);
        checkOutput("add block", 32'(es_rf_collect[38]), 32'd0);
        checkOutput("add rf_we", 32'(es_rf_collect[37]), 32'd1);
        checkOutput("add fwd", es_rf_collect[31:0], 32'd12);
        checkOutput("add pc", es_to_ms_bus[31:0], 32'h1c00_0000);
        @(negedge clk);
        checkOutput("add drained", 32'(es_to_ms_valid), 32'd0);

        runAlu("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
        runAlu("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        runAlu("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        runAlu("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        runAlu("nor", ALU_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F);
        runAlu("or", ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        runAlu("xor", ALU_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0);
        runAlu("sll", ALU_SLL, 32'd1, 32'h0000_0025, 32'h0000_0020);
        runAlu("srl", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        runAlu("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        runAlu("lui", ALU_LUI, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000);
        runAlu("noop", -1, 32'h1111_1111, 32'h2222_2222, 32'h0);
        runAlu("mul_w", ALU_MUL_W, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        runAlu("mulh_w", ALU_MULH_W, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF);
        runAlu("mulh_wu", ALU_MULH_WU, 32'hFFFF_FFFF, 32'd3, 32'd2);
        runAlu("mulh_w min", ALU_MULH_W, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

        runDiv("div_w 100/7", ALU_DIV_W, 32'd100, 32'd7, 32'd14, 33);
        runDiv("mod_w 100/7", ALU_MOD_W, 32'd100, 32'd7, 32'd2, 33);
        runDiv("div_w -100/7", ALU_DIV_W, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
        runDiv("mod_w -100/7", ALU_MOD_W, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
        runDiv("div_w 100/-7", ALU_DIV_W, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
        runDiv("div_wu x/0", ALU_DIV_WU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, EARLY_LAT);
        runDiv("mod_wu x/0", ALU_MOD_WU, 32'h0000_1234, 32'd0, 32'h0000_1234, EARLY_LAT);
        runDiv("div_w -5/0", ALU_DIV_W, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, EARLY_LAT);
        runDiv("mod_w -5/0", ALU_MOD_W, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, EARLY_LAT);
        runDiv("div_w min/-1", ALU_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        runDiv("mod_w min/-1", ALU_MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        runDiv("div_wu big", ALU_DIV_WU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 33);
        runDiv("mod_w -3/7", ALU_MOD_W, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFD, EARLY_LAT);

        // Byte store at the top lane
        applyStimulus(makeBus(ALU_ADD, 1'b0, 32'h1000, 32'd3, 1'b1, 1'b0, 5'd0, 32'h1234_56AB, 32'h1c00_0300), 8'b0000_0001);
        checkOutput("st_b en", 32'(data_sram_en), 32'd1);
        checkOutput("st_b we", 32'(data_sram_we), 32'b1000);
        checkOutput("st_b wdata", data_sram_wdata, 32'hABAB_ABAB);
        checkOutput("st_b addr", data_sram_addr, 32'h0000_1003);
        @(negedge clk);

        // Halfword stores in both halves
        applyStimulus(makeBus(ALU_ADD, 1'b0, 32'h1000, 32'd2, 1'b1, 1'b0, 5'd0, 32'h0000_BEEF, 32'h1c00_0304), 8'b0000_0010);
        checkOutput("st_h hi we", 32'(data_sram_we), 32'b1100);
        checkOutput("st_h wdata", data_sram_wdata, 32'hBEEF_BEEF);
        @(negedge clk);
        applyStimulus(makeBus(ALU_ADD, 1'b0, 32'h1000, 32'd0, 1'b1, 1'b0, 5'd0, 32'h0000_BEEF, 32'h1c00_0308), 8'b0000_0010);
        checkOutput("st_h lo we", 32'(data_sram_we), 32'b0011);
        @(negedge clk);

        // Load: blocks forwarding, carries load type and low address bits
        applyStimulus(makeBus(ALU_ADD, 1'b1, 32'h2000, 32'd6, 1'b0, 1'b1, 5'd7, 32'h0, 32'h1c00_030c), 8'b1000_0000);
        checkOutput("ld_w en", 32'(data_sram_en), 32'd1);
        checkOutput("ld_w we", 32'(data_sram_we), 32'd0);
        checkOutput("ld_w block", 32'(es_rf_collect[38]), 32'd1);
        checkOutput("ld_w type", 32'(es_to_ms_bus[77]), 32'd1);
        checkOutput("ld_w addr lo", 32'(es_to_ms_bus[72:71]), 32'd2);
        @(negedge clk);

        // Back-pressure from memory stage with a second bundle waiting
        ms_allowin = 1'b0;
        applyStimulus(makeBus(ALU_ADD, 1'b0, 32'd20, 32'd22, 1'b1, 1'b0, 5'd0, 32'hCAFE_F00D, 32'h1c00_0400), 8'b0000_0100);
        ds_to_es_bus   = makeBus(ALU_ADD, 1'b0, 32'd1, 32'd1, 1'b0, 1'b1, 5'd2, 32'h0, 32'h1c00_0404);
        mem_inst_bus   = 8'h00;
        ds_to_es_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("stall allowin", 32'(es_allowin), 32'd0);
            checkOutput("stall result", es_to_ms_bus[63:32], 32'd42);
            checkOutput("stall sram_en", 32'(data_sram_en), 32'd0);
            @(negedge clk);
        end
        ms_allowin = 1'b1;
        #1;
        checkOutput("release sram_en", 32'(data_sram_en), 32'd1);
        checkOutput("release we", 32'(data_sram_we), 32'b1111);
        checkOutput("release wdata", data_sram_wdata, 32'hCAFE_F00D);
        checkOutput("release allowin", 32'(es_allowin), 32'd1);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        checkOutput("next valid", 32'(es_to_ms_valid), 32'd1);
        checkOutput("next result", es_to_ms_bus[63:32], 32'd2);
        checkOutput("next pc", es_to_ms_bus[31:0], 32'h1c00_0404);
        @(negedge clk);
        checkOutput("next drained", 32'(es_to_ms_valid), 32'd0);

        // Reset in the 10th busy cycle of a divide
        applyStimulus(makeBus(ALU_DIV_W, 1'b0, 32'd100, 32'd7, 1'b0, 1'b1, 5'd9, 32'h0, 32'h1c00_0500), 8'h00);
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("abort valid", 32'(es_to_ms_valid), 32'd0);
        checkOutput("abort allowin", 32'(es_allowin), 32'd1);
        checkOutput("abort rf_we", 32'(es_rf_collect[37]), 32'd0);
        checkOutput("abort block", 32'(es_rf_collect[38]), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        runAlu("post-abort add", ALU_ADD, 32'd3, 32'd4, 32'd7);
        runDiv("post-abort div", ALU_DIV_W, 32'd100, 32'd7, 32'd14, 33);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
